// File: rtl/uart_cmd_exec.sv
// Command executor between the packet UART receiver and sender: validates a
// 16-byte command frame, updates or queries the segment display, and replies.
module uart_cmd_exec #(
    parameter logic [23:0] SEG_INIT = 24'hfecda9,
    parameter logic [7:0]  HDR_RX   = 8'hA5,
    parameter logic [7:0]  HDR_TX   = 8'h5A
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         recv_done,
    input  logic [127:0] recv_data,
    input  logic         tx_busy,
    output logic         send_en,
    output logic [127:0] send_data,
    output logic [23:0]  seg_data,
    output logic         seg_en,
    output logic         busy,
    output logic [7:0]   drop_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUM  = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_RSUM = 3'd3;
    localparam logic [2:0] S_TX   = 3'd4;

    localparam logic [3:0] LAST_BYTE = 4'd14;

    logic [2:0]   r_state,     w_state_nxt;
    logic [127:0] r_frame,     w_frame_nxt;
    logic [7:0]   r_sum,       w_sum_nxt;
    logic [3:0]   r_cnt,       w_cnt_nxt;
    logic         r_send_en,   w_send_en_nxt;
    logic [127:0] r_send_data, w_send_data_nxt;
    logic [23:0]  r_seg_data,  w_seg_data_nxt;
    logic         r_seg_en,    w_seg_en_nxt;
    logic         r_busy,      w_busy_nxt;
    logic [7:0]   r_drop_cnt,  w_drop_cnt_nxt;

    logic [6:0]   w_lo;
    logic [127:0] w_src;
    logic [7:0]   w_byte;
    logic [7:0]   w_sum_add;
    logic [7:0]   w_hdr;
    logic [7:0]   w_cmd;
    logic [7:0]   w_chk;
    logic [7:0]   w_status;
    logic         w_set;
    logic [23:0]  w_seg_new;
    logic         w_en_new;
    logic [127:0] w_reply;

    // Byte r_cnt of either the received frame (SUM) or the reply (RSUM).
    assign w_lo      = 7'd120 - {r_cnt, 3'b000};
    assign w_src     = (r_state == S_RSUM) ? r_send_data : r_frame;
    assign w_byte    = w_src[w_lo +: 8];
    assign w_sum_add = r_sum + w_byte;

    assign w_hdr = r_frame[127:120];
    assign w_cmd = r_frame[119:112];
    assign w_chk = r_frame[7:0];

    always_comb begin
        w_status = 8'h00;
        if (w_hdr != HDR_RX)
            w_status = 8'h03;
        else if (r_sum != w_chk)
            w_status = 8'h01;
        else if (w_cmd != 8'h01 && w_cmd != 8'h02)
            w_status = 8'h02;
    end

    assign w_set     = (w_status == 8'h00) && (w_cmd == 8'h01);
    assign w_seg_new = w_set ? r_frame[111:88] : r_seg_data;
    assign w_en_new  = w_set ? r_frame[80] : r_seg_en;
    assign w_reply   = {HDR_TX, w_cmd, w_status, w_seg_new, 7'b0, w_en_new, 64'b0, 8'h00};

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame;
        w_sum_nxt       = r_sum;
        w_cnt_nxt       = r_cnt;
        w_send_en_nxt   = 1'b0;
        w_send_data_nxt = r_send_data;
        w_seg_data_nxt  = r_seg_data;
        w_seg_en_nxt    = r_seg_en;
        w_drop_cnt_nxt  = r_drop_cnt;

        if (recv_done && r_state != S_IDLE && r_drop_cnt != 8'hFF)
            w_drop_cnt_nxt = r_drop_cnt + 8'd1;

        case (r_state)
            S_IDLE: begin
                if (recv_done) begin
                    w_frame_nxt = recv_data;
                    w_sum_nxt   = 8'h00;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_SUM;
                end
            end
            S_SUM: begin
                w_sum_nxt = w_sum_add;
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == LAST_BYTE)
                    w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_seg_data_nxt  = w_seg_new;
                w_seg_en_nxt    = w_en_new;
                w_send_data_nxt = w_reply;
                w_sum_nxt       = 8'h00;
                w_cnt_nxt       = 4'd0;
                w_state_nxt     = S_RSUM;
            end
            S_RSUM: begin
                w_sum_nxt = w_sum_add;
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == LAST_BYTE) begin
                    w_send_data_nxt[7:0] = w_sum_add;
                    w_send_en_nxt        = ~tx_busy;
                    w_state_nxt          = S_TX;
                end
            end
            S_TX: begin
                // Pulse already out: done. Otherwise fire once the sender is free.
                if (r_send_en)
                    w_state_nxt = S_IDLE;
                else if (!tx_busy)
                    w_send_en_nxt = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_sum       <= 8'h00;
            r_cnt       <= 4'd0;
            r_send_en   <= 1'b0;
            r_send_data <= '0;
            r_seg_data  <= SEG_INIT;
            r_seg_en    <= 1'b1;
            r_busy      <= 1'b0;
            r_drop_cnt  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_sum       <= w_sum_nxt;
            r_cnt       <= w_cnt_nxt;
            r_send_en   <= w_send_en_nxt;
            r_send_data <= w_send_data_nxt;
            r_seg_data  <= w_seg_data_nxt;
            r_seg_en    <= w_seg_en_nxt;
            r_busy      <= w_busy_nxt;
            r_drop_cnt  <= w_drop_cnt_nxt;
        end
    end

    assign send_en   = r_send_en;
    assign send_data = r_send_data;
    assign seg_data  = r_seg_data;
    assign seg_en    = r_seg_en;
    assign busy      = r_busy;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_uart_cmd_exec.sv
// Directed bench for uart_cmd_exec: frame execution, status codes, latency,
// sender back-pressure, dropped frames and mid-frame reset.
module tb_uart_cmd_exec;

    localparam logic [127:0] F_SET = 128'hA501123456010000_0000000000000043;
    localparam logic [127:0] R_SET = 128'h5A01001234560100_00000000000000F8;
    localparam logic [127:0] F_BAD = 128'hA501123456010000_0000000000000044;
    localparam logic [127:0] R_BAD = 128'h5A0101FECDA90100_00000000000000D1;
    localparam logic [127:0] F_UNK = 128'hA507000000000000_00000000000000AC;
    localparam logic [127:0] R_UNK = 128'h5A07021234560100_0000000000000000;
    localparam logic [127:0] F_HDR = 128'h0001998877010000_000000000000009A;
    localparam logic [127:0] R_HDR = 128'h5A01031234560100_00000000000000FB;
    localparam logic [127:0] F_OFF = 128'hA501ABCDEF000000_000000000000000D;
    localparam logic [127:0] R_OFF = 128'h5A0100ABCDEF0000_00000000000000C2;
    localparam logic [127:0] F_QRY = 128'hA502000000000000_00000000000000A7;
    localparam logic [127:0] R_QRY = 128'h5A0200ABCDEF0000_00000000000000C3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         recv_done;
    logic [127:0] recv_data;
    logic         tx_busy;
    logic         send_en;
    logic [127:0] send_data;
    logic [23:0]  seg_data;
    logic         seg_en;
    logic         busy;
    logic [7:0]   drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    int p0;

    uart_cmd_exec dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .recv_done (recv_done),
        .recv_data (recv_data),
        .tx_busy   (tx_busy),
        .send_en   (send_en),
        .send_data (send_data),
        .seg_data  (seg_data),
        .seg_en    (seg_en),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (send_en) n_pulse++;

    initial begin
        #500us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Full frame with tx_busy low; negedge k after the accepting edge is cycle T+k.
    task automatic run_frame(input string tag, input logic [127:0] f, input logic [127:0] rep,
                             input logic [23:0] prev_seg, input logic [23:0] seg, input logic en);
        @(negedge clk); recv_data = f; recv_done = 1'b1;
        @(negedge clk); recv_done = 1'b0;
        chk({tag, " busy T+1"}, busy, 1'b1);
        repeat (15) @(negedge clk);
        chk({tag, " seg T+16"}, seg_data, prev_seg);
        @(negedge clk);
        chk({tag, " seg T+17"}, seg_data, seg);
        chk({tag, " en T+17"}, seg_en, en);
        repeat (14) @(negedge clk);
        chk({tag, " send_en T+31"}, send_en, 1'b0);
        @(negedge clk);
        chk({tag, " send_en T+32"}, send_en, 1'b1);
        chk({tag, " send_data T+32"}, send_data, rep);
        @(negedge clk);
        chk({tag, " send_en T+33"}, send_en, 1'b0);
        chk({tag, " busy T+33"}, busy, 1'b0);
        chk({tag, " send_data T+33"}, send_data, rep);
    endtask

    initial begin
        rst_n = 1'b0; recv_done = 1'b0; recv_data = '0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst seg_data", seg_data, 24'hfecda9);
        chk("rst seg_en", seg_en, 1'b1);
        chk("rst send_en", send_en, 1'b0);
        chk("rst send_data", send_data, 128'h0);
        chk("rst drop_cnt", drop_cnt, 8'h00);
        chk("rst busy", busy, 1'b0);

        run_frame("badsum", F_BAD, R_BAD, 24'hfecda9, 24'hfecda9, 1'b1);
        run_frame("set",    F_SET, R_SET, 24'hfecda9, 24'h123456, 1'b1);
        run_frame("unkcmd", F_UNK, R_UNK, 24'h123456, 24'h123456, 1'b1);
        run_frame("badhdr", F_HDR, R_HDR, 24'h123456, 24'h123456, 1'b1);
        run_frame("setoff", F_OFF, R_OFF, 24'h123456, 24'habcdef, 1'b0);

        // Sender busy from T to T+50.
        @(negedge clk); tx_busy = 1'b1; recv_data = F_QRY; recv_done = 1'b1; p0 = n_pulse;
        @(negedge clk); recv_done = 1'b0;
        repeat (49) @(negedge clk);
        chk("txbusy no pulse", n_pulse, p0);
        chk("txbusy busy", busy, 1'b1);
        chk("txbusy send_data", send_data, R_QRY);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("txbusy send_en after release", send_en, 1'b1);
        @(negedge clk);
        chk("txbusy send_en clear", send_en, 1'b0);
        chk("txbusy idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("txbusy one pulse", n_pulse, p0 + 1);

        // Frames arriving at T+5 and T+20 are dropped.
        @(negedge clk); recv_data = F_QRY; recv_done = 1'b1; p0 = n_pulse;
        @(negedge clk); recv_done = 1'b0;
        repeat (4) @(negedge clk);
        recv_data = F_SET; recv_done = 1'b1;
        @(negedge clk); recv_done = 1'b0;
        repeat (14) @(negedge clk);
        recv_data = F_OFF; recv_done = 1'b1;
        @(negedge clk); recv_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("drop cnt2", drop_cnt, 8'd2);
        chk("drop one reply", n_pulse, p0 + 1);
        chk("drop reply data", send_data, R_QRY);
        chk("drop seg kept", seg_data, 24'habcdef);

        // 300 drops while parked in TX saturate the counter.
        @(negedge clk); tx_busy = 1'b1; recv_data = F_QRY; recv_done = 1'b1; p0 = n_pulse;
        @(negedge clk); recv_done = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            recv_done = 1'b1;
            @(negedge clk); recv_done = 1'b0;
            @(negedge clk);
        end
        chk("drop saturate", drop_cnt, 8'hFF);
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat one reply", n_pulse, p0 + 1);
        chk("sat reply data", send_data, R_QRY);

        // Reset asserted at T+10 for two cycles.
        @(negedge clk); recv_data = F_SET; recv_done = 1'b1; p0 = n_pulse;
        @(negedge clk); recv_done = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst seg_data", seg_data, 24'hfecda9);
        chk("mrst seg_en", seg_en, 1'b1);
        chk("mrst send_en", send_en, 1'b0);
        chk("mrst send_data", send_data, 128'h0);
        chk("mrst drop_cnt", drop_cnt, 8'h00);
        chk("mrst busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mrst no pulse", n_pulse, p0);
        chk("mrst idle", busy, 1'b0);
        chk("mrst seg held", seg_data, 24'hfecda9);

        run_frame("postrst", F_SET, R_SET, 24'hfecda9, 24'h123456, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_exec.md
Name: uart_cmd_exec

Overview:
- Command executor directly downstream of the 128-bit packet UART receiver.
- Validates each received 16-byte frame by header and checksum, then executes a small command set.
- Commands update the 6-digit segment display data and enable, or query them.
- Builds a 16-byte reply frame and hands it to the 128-bit packet UART sender.
- Replaces the constant display drive and the plain loopback path in the top level.

Parameters:
SEG_INIT, 24'hfecda9, display data value after reset
HDR_RX, 8'hA5, required header byte of a command frame
HDR_TX, 8'h5A, header byte of every reply frame

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous active-low reset
recv_done  input  1  one-cycle pulse; recv_data is valid in the same cycle
recv_data  input  128  received frame; byte k = recv_data[127-8k -: 8], byte 0 received first
tx_busy  input  1  sender busy; high while a frame is being transmitted
send_en  output  1  one-cycle start pulse to the sender
send_data  output  128  reply frame, same byte ordering as recv_data
seg_data  output  24  6 hex digits to the segment driver
seg_en  output  1  segment display enable
busy  output  1  high in every state except IDLE
drop_cnt  output  8  saturating count of frames dropped while busy

Behaviour:
- Reset values: seg_data = SEG_INIT; seg_en = 1; send_en = 0; send_data = 0; drop_cnt = 0; state = IDLE.
- Reset is asynchronous and may occur in any state, mid-operation included. It aborts the frame and returns every output to its reset value. No send_en is issued for the aborted frame.
- Command frame layout:
  - byte0 = HDR_RX; byte1 = cmd; bytes 2..14 = payload.
  - byte15 = (sum of bytes 0..14) mod 256.
- States and transitions:
  - IDLE: on recv_done, latch recv_data into the frame register, clear the sum and the byte counter, go to SUM.
  - SUM: add one byte per cycle, bytes 0..14, 15 cycles total. The counter is 4-bit. Go to EXEC after byte 14.
  - EXEC: one cycle. Status priority: header mismatch -> 8'h03; else checksum mismatch -> 8'h01; else unknown cmd -> 8'h02; else 8'h00.
    - cmd 8'h01 with status 0: seg_data <= {byte2, byte3, byte4}; seg_en <= byte5[0].
    - cmd 8'h02 with status 0: no state change (query).
    - seg_data and seg_en change only in EXEC with status 0 and cmd 8'h01.
    - Build the reply: byte0 = HDR_TX; byte1 = received cmd; byte2 = status; bytes 3..5 = seg_data after the update; byte6 = {7'b0, seg_en after the update}; bytes 7..14 = 0.
  - RSUM: 15 cycles. Accumulate reply bytes 0..14 sequentially, then write byte15 = sum mod 256.
  - TX: assert send_en for exactly one cycle in the first cycle in which tx_busy = 0, then go to IDLE. Wait indefinitely while tx_busy = 1.
- send_data changes only in EXEC and RSUM. It is stable from entry to TX until the next frame's EXEC.
- Latency, with recv_done sampled in cycle T:
  - SUM occupies T+1..T+15; EXEC is T+16.
  - seg_data and seg_en are visible at T+17.
  - RSUM occupies T+17..T+31.
  - Earliest send_en is T+32.
- recv_done in any state other than IDLE: the frame is discarded and drop_cnt increments, saturating at 8'hFF. recv_done in IDLE is always accepted.
- All sums are 8-bit wrap-around.

Test Plan:
- Set display: A5 01 12 34 56 01, bytes 6..14 = 00, byte15 = 43; tx_busy = 0.
  - At T+17: seg_data = 24'h123456, seg_en = 1.
  - At T+32: send_en pulse; send_data = 5A 01 00 12 34 56 01, 00 x8, F8.
- Bad checksum: same frame with byte15 = 44.
  - seg_data stays SEG_INIT.
  - Reply byte2 = 01; bytes 3..5 = FE CD A9; byte6 = 01.
- Unknown cmd 07 with a valid checksum and bad header 00 with a valid checksum: statuses 02 and 03 respectively; no display change.
- Hold tx_busy = 1 from T to T+50, then release.
  - No send_en before release; exactly one send_en in the cycle after release.
- Pulse recv_done at T+5 and T+20 during an active frame.
  - drop_cnt = 2; only one reply is sent.
  - 300 dropped frames -> drop_cnt = FF.
- Assert sys_rst_n low at T+10 for 2 cycles.
  - All outputs return to reset values; no send_en follows.
  - A new valid frame afterwards completes normally.
